// File: rtl/ysyx_24070016_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns PC and IR and fetches over a valid/ready request.
// It steps each instruction through decode/execute/write-back and halts on ebreak, bus error or misaligned PC.
module ysyx_24070016_seq_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   output logic [31:0] ifu_req_addr,
   input  logic        ifu_resp_valid,
   input  logic [31:0] ifu_resp_data,
   input  logic        ifu_resp_err,
   output logic [31:0] inst,
   input  logic        dec_rf_wen,
   input  logic        dec_ebreak,
   input  logic [31:0] next_pc,
   input  logic [31:0] halt_ret,
   output logic [31:0] pc,
   output logic        rf_we,
   output logic        commit,
   output logic [31:0] commit_pc,
   output logic        halt,
   output logic        fault,
   output logic [31:0] halt_code,
   output logic [63:0] instret,
   output logic [63:0] cycles
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_FETCH_REQ  = 3'd0,
      S_FETCH_WAIT = 3'd1,
      S_DECODE     = 3'd2,
      S_EXEC       = 3'd3,
      S_WB         = 3'd4,
      S_HALT       = 3'd5
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic        halt_q;
   logic        fault_q;
   logic [31:0] halt_code_q;
   logic [63:0] instret_q;
   logic [63:0] cycles_q;

   logic [63:0] instret_d;
   logic [63:0] cycles_d;
   logic        in_wb;
   logic        misalign;

   assign in_wb     = (state_q == S_WB);
   assign misalign  = |next_pc[1:0];
   assign instret_d = instret_q + 64'd1;
   assign cycles_d  = cycles_q + 64'd1;

   // ebreak wins over misalignment: it still retires, but never writes the register file
   assign rf_we  = in_wb & dec_rf_wen & ~dec_ebreak & ~misalign;
   assign commit = in_wb & (dec_ebreak | ~misalign);

   assign ifu_req_valid = (state_q == S_FETCH_REQ);
   assign ifu_req_addr  = pc_q;
   assign inst          = inst_q;
   assign pc            = pc_q;
   assign commit_pc     = pc_q;
   assign halt          = halt_q;
   assign fault         = fault_q;
   assign halt_code     = halt_code_q;
   assign instret       = instret_q;
   assign cycles        = cycles_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FETCH_REQ;
         pc_q        <= RESET_PC;
         inst_q      <= NOP;
         halt_q      <= 1'b0;
         fault_q     <= 1'b0;
         halt_code_q <= 32'h0;
         instret_q   <= 64'h0;
         cycles_q    <= 64'h0;
      end else begin
         if (state_q != S_HALT) begin
            cycles_q <= cycles_d;
         end
         case (state_q)
            S_FETCH_REQ: begin
               if (ifu_req_ready) begin
                  state_q <= S_FETCH_WAIT;
               end
            end
            S_FETCH_WAIT: begin
               if (ifu_resp_valid) begin
                  if (ifu_resp_err) begin
                     halt_q  <= 1'b1;
                     fault_q <= 1'b1;
                     state_q <= S_HALT;
                  end else begin
                     inst_q  <= ifu_resp_data;
                     state_q <= S_DECODE;
                  end
               end
            end
            S_DECODE: state_q <= S_EXEC;
            S_EXEC:   state_q <= S_WB;
            S_WB: begin
               if (dec_ebreak) begin
                  instret_q   <= instret_d;
                  halt_code_q <= halt_ret;
                  halt_q      <= 1'b1;
                  state_q     <= S_HALT;
               end else if (misalign) begin
                  halt_q  <= 1'b1;
                  fault_q <= 1'b1;
                  state_q <= S_HALT;
               end else begin
                  pc_q      <= next_pc;
                  instret_q <= instret_d;
                  state_q   <= S_FETCH_REQ;
               end
            end
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_FETCH_REQ;
         endcase
      end
   end

endmodule

// File: doc/ysyx_24070016_seq_ctrl.md
# ysyx_24070016_seq_ctrl

Multi-cycle instruction sequencer for the NPC core. It owns the PC and the instruction register and fetches over a valid/ready request plus valid response interface. It steps each instruction through decode, execute and write-back, gating register-file writes and retiring instructions. It halts the core on `ebreak`, on a fetch error or on a misaligned next PC.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: PC loaded on reset.

Ports:
- `clk`  in  1  core clock; every register updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ifu_req_valid`  out  1  fetch request valid.
- `ifu_req_ready`  in  1  memory accepts the request.
- `ifu_req_addr`  out  32  fetch address, equal to `pc`.
- `ifu_resp_valid`  in  1  fetch data valid.
- `ifu_resp_data`  in  32  fetched instruction.
- `ifu_resp_err`  in  1  fetch bus error; qualified by `ifu_resp_valid`.
- `inst`  out  32  instruction register, driven into the decoder.
- `dec_rf_wen`  in  1  decoder register-file write request.
- `dec_ebreak`  in  1  decoder ebreak flag.
- `next_pc`  in  32  next PC computed by the execute stage.
- `halt_ret`  in  32  current value of GPR a0.
- `pc`  out  32  current PC.
- `rf_we`  out  1  qualified register-file write enable.
- `commit`  out  1  one-cycle pulse per retired instruction.
- `commit_pc`  out  32  PC of the retiring instruction; valid only while `commit`=1.
- `halt`  out  1  core stopped, sticky.
- `fault`  out  1  the halt was abnormal, sticky.
- `halt_code`  out  32  a0 value captured at `ebreak`.
- `instret`  out  64  count of retired instructions.
- `cycles`  out  64  cycles since reset.

## Operation
- States: FETCH_REQ, FETCH_WAIT, DECODE, EXEC, WB, HALT. Reset state is FETCH_REQ.
- Reset values:
  - `pc`=`RESET_PC`; `inst`=`32'h0000_0013` (nop).
  - `halt`, `fault`, `rf_we`, `commit` = 0.
  - `halt_code`, `instret`, `cycles` = 0.
- FETCH_REQ:
  - `ifu_req_valid`=1 and `ifu_req_addr`=`pc`, both held stable until `ifu_req_ready`=1.
  - On `ifu_req_valid & ifu_req_ready`, move to FETCH_WAIT.
- FETCH_WAIT:
  - Wait for `ifu_resp_valid`.
  - With `ifu_resp_err`=0: latch `inst`<=`ifu_resp_data`, go to DECODE.
  - With `ifu_resp_err`=1: go to HALT with `fault`=1; `inst` is unchanged.
- `ifu_resp_valid` in any state other than FETCH_WAIT is ignored. At most one request is outstanding.
- DECODE: one cycle; the decoder settles from `inst`. EXEC: one cycle; the execute stage settles `next_pc` and result.
- WB, normal case (`dec_ebreak`=0 and `next_pc[1:0]`=0):
  - `rf_we`=`dec_rf_wen`, combinational, this cycle only.
  - `commit`=1 and `commit_pc`=`pc`.
  - `pc`<=`next_pc`; `instret`+=1; go to FETCH_REQ.
- WB with `dec_ebreak`=1:
  - `rf_we`=0, `commit`=1, `instret`+=1.
  - `halt_code`<=`halt_ret`; `pc` is unchanged; go to HALT with `fault`=0.
- WB with `dec_ebreak`=0 and `next_pc[1:0]`≠0:
  - `rf_we`=0, `commit`=0; `pc` is unchanged; go to HALT with `fault`=1.
- When both conditions hold, `dec_ebreak` has priority over misalignment.
- HALT is terminal until `rst`. In HALT: `halt`=1, `ifu_req_valid`=0, `rf_we`=0, `commit`=0, and `cycles` freezes.
- `cycles` increments every cycle outside HALT. Both counters are 64-bit and wrap modulo 2^64.
- `rf_we` is 0 in every state except WB.

## Timing
- Zero-wait memory (`ifu_req_ready`=1; response the cycle after acceptance): exactly 5 cycles per instruction, with `commit` on every 5th cycle.
- Each cycle of `ifu_req_ready`=0 and each cycle of response delay adds one cycle.
- `inst` changes only on the edge leaving FETCH_WAIT. It is stable through DECODE, EXEC and WB.
- `halt` and `fault` are registered: they assert in the cycle after the WB or FETCH_WAIT that caused them.
- `rst` has priority over all state activity.
  - Asserting `rst` mid-fetch abandons the outstanding request. The memory side is reset by the same `rst`, so no stale response follows.
  - The first cycle after `rst` deasserts is FETCH_REQ with `ifu_req_addr`=`RESET_PC`.

## Test plan
- Zero-wait memory returning addi x1,x0,5 at `32'h8000_0000`, with `next_pc`=`pc`+4:
  - `commit` pulses in cycles 5, 10, 15 after reset.
  - `commit_pc` = `32'h8000_0000`, then `…_0004`, then `…_0008`.
  - `rf_we`=1 in each WB; `instret`=3 after the third commit.
- `ifu_req_ready` low for 3 cycles, then the response delayed 2 cycles:
  - `ifu_req_addr` stays stable while waiting.
  - `commit` occurs at cycle 10.
  - A spurious `ifu_resp_valid` pulsed during FETCH_REQ has no effect.
- ebreak (`32'h0010_0073`) with `halt_ret`=`32'h0000_002A`:
  - `halt`=1, `fault`=0, `halt_code`=`32'h2A`.
  - `rf_we`=0; `pc` is unchanged.
  - `ifu_req_valid` stays 0 for 20 following cycles.
- `ifu_resp_err`=1 on the second fetch:
  - `halt`=1 and `fault`=1.
  - `instret`=1; `inst` keeps the first instruction.
- `next_pc`=`32'h8000_0006`:
  - HALT with `fault`=1, `commit`=0, and `pc`=`32'h8000_0000`.
- Reset mid-run:
  - Assert `rst` for 1 cycle during FETCH_WAIT of the third instruction.
  - All outputs return to reset values.
  - The next request is to `RESET_PC`, and `instret` restarts from 0.
